// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_keyboard_rx_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Odd parity over the data byte plus its parity bit.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic parity_bit);
    return ^{data, parity_bit};
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_input_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter for one PS/2 pin.
module ps2_keyboard_rx_input_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] run_cnt;

  // Bring the asynchronous pin into the clk domain; idle bus level is 1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  // Change the filtered level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      level   <= 1'b1;
      run_cnt <= '0;
    end else if (sync2 == level) begin
      run_cnt <= '0;
    end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
      level   <= sync2;
      run_cnt <= '0;
    end else begin
      run_cnt <= run_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host frame receiver with a first-word-fall-through scancode FIFO.
module ps2_keyboard_rx
  import ps2_keyboard_rx_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned CHECK_PARITY   = 1,
  parameter int unsigned CHECK_STOP     = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow,
  input  logic       overflow_clr,
  output logic       busy
);

  localparam int unsigned DW = PS2_DATA_BITS;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Conditioned pin levels and falling-edge detect on the PS/2 clock.
  logic clk_f;
  logic dat_f;
  logic clk_f_q;
  logic fall;

  ps2_keyboard_rx_input_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (ps2_clk),
    .level   (clk_f)
  );

  ps2_keyboard_rx_input_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (ps2_dat),
    .level   (dat_f)
  );

  // Previous filtered clock level for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) clk_f_q <= 1'b1;
    else          clk_f_q <= clk_f;
  end

  assign fall = clk_f_q & ~clk_f;

  // Frame state and datapath.
  ps2_state_e    state;
  ps2_state_e    state_nxt;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_cnt_nxt;
  logic [DW-1:0] shreg;
  logic [DW-1:0] shreg_nxt;
  logic          parity_bit;
  logic          parity_bit_nxt;
  logic [TW-1:0] to_cnt;
  logic [TW-1:0] to_cnt_nxt;
  logic          par_ok;
  logic          push_c;
  logic          perr_nxt;
  logic          ferr_nxt;

  assign par_ok = odd_parity_ok(shreg, parity_bit);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      parity_bit <= parity_bit_nxt;
      to_cnt     <= to_cnt_nxt;
      parity_err <= perr_nxt;
      frame_err  <= ferr_nxt;
      busy       <= (state_nxt != ST_IDLE);
    end
  end

  // Next-state logic: advance on PS/2 falls; a mid-frame timeout overrides a fall.
  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    shreg_nxt      = shreg;
    parity_bit_nxt = parity_bit;
    to_cnt_nxt     = '0;
    push_c         = 1'b0;
    perr_nxt       = 1'b0;
    ferr_nxt       = 1'b0;

    if ((state != ST_IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES - 1))) begin
      state_nxt = ST_IDLE;
      ferr_nxt  = 1'b1;
    end else begin
      if (state != ST_IDLE) begin
        to_cnt_nxt = fall ? '0 : (to_cnt + TW'(1));
      end
      if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!dat_f) begin
              state_nxt   = ST_DATA;
              bit_cnt_nxt = '0;
            end else begin
              ferr_nxt = 1'b1;
            end
          end
          ST_DATA: begin
            shreg_nxt = {dat_f, shreg[DW-1:1]};
            if (bit_cnt == 3'd7) begin
              state_nxt = ST_PARITY;
            end else begin
              bit_cnt_nxt = bit_cnt + 3'd1;
            end
          end
          ST_PARITY: begin
            parity_bit_nxt = dat_f;
            state_nxt      = ST_STOP;
          end
          ST_STOP: begin
            state_nxt = ST_IDLE;
            perr_nxt  = !par_ok;
            ferr_nxt  = !dat_f;
            push_c    = !(((CHECK_PARITY != 0) && !par_ok) ||
                          ((CHECK_STOP != 0) && !dat_f));
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  // Scancode FIFO: extra pointer MSB distinguishes full from empty.
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop_c;
  logic          wr_en;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_c      = rd_valid && rd_ready;
  assign wr_en      = push_c && (!fifo_full || pop_c);
  assign rd_valid   = !fifo_empty;
  assign rd_data    = rd_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

  // FIFO pointers and sticky overflow flag; a new overflow beats a clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c) rd_ptr <= rd_ptr + PW'(1);
      if (push_c && fifo_full && !pop_c) overflow <= 1'b1;
      else if (overflow_clr)             overflow <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset since reads are gated by rd_valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= shreg;
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx with a byte scoreboard per DUT instance.
module tb_ps2_keyboard_rx;
  import ps2_keyboard_rx_pkg::*;

  localparam int HALF = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       overflow_clr = 1'b0;
  logic       rd_ready_a = 1'b0;
  logic       rd_ready_b = 1'b0;
  logic [7:0] rd_data_a, rd_data_b;
  logic       rd_valid_a, rd_valid_b;
  logic       parity_err_a, parity_err_b;
  logic       frame_err_a, frame_err_b;
  logic       overflow_a, overflow_b;
  logic       busy_a, busy_b;

  ps2_keyboard_rx dut_a (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_ready(rd_ready_a),
    .parity_err(parity_err_a), .frame_err(frame_err_a), .overflow(overflow_a),
    .overflow_clr(overflow_clr), .busy(busy_a)
  );

  ps2_keyboard_rx #(.CHECK_PARITY(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_ready(rd_ready_b),
    .parity_err(parity_err_b), .frame_err(frame_err_b), .overflow(overflow_b),
    .overflow_clr(overflow_clr), .busy(busy_b)
  );

  int checks = 0;
  int failures = 0;
  int perr_a = 0, ferr_a = 0, perr_b = 0, ferr_b = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  // Pulse counters for the error outputs.
  always @(negedge clk) begin
    if (parity_err_a) perr_a = perr_a + 1;
    if (frame_err_a)  ferr_a = ferr_a + 1;
    if (parity_err_b) perr_b = perr_b + 1;
    if (frame_err_b)  ferr_b = ferr_b + 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [PS2_FRAME_BITS-1:0] mk_frame(input logic [7:0] d,
                                                         input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  function automatic logic good_par(input logic [7:0] d);
    return ~^d;
  endfunction

  // Drive the first nbits of a frame, LSB (start bit) first.
  task automatic send_bits(input logic [PS2_FRAME_BITS-1:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    wait_cycles(HALF);
  endtask

  task automatic send_good(input logic [7:0] d);
    send_bits(mk_frame(d, good_par(d), 1'b1), PS2_FRAME_BITS);
  endtask

  // Wait for dut_a data, compare with scoreboard head, then pop it.
  task automatic pop_a(input string name);
    int n;
    logic [7:0] exp;
    n = 0;
    @(negedge clk);
    while (!rd_valid_a && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (!rd_valid_a) begin
      failures++;
      $display("FAIL %s: rd_valid=0 required 1 (timeout)", name);
    end else if (qa.size() == 0) begin
      failures++;
      $display("FAIL %s: rd_data=%h but scoreboard expected nothing", name, rd_data_a);
    end else begin
      exp = qa.pop_front();
      if (rd_data_a !== exp) begin
        failures++;
        $display("FAIL %s: rd_data=%h required %h", name, rd_data_a, exp);
      end
      rd_ready_a = 1'b1;
      @(negedge clk);
      rd_ready_a = 1'b0;
    end
  endtask

  task automatic pop_b(input string name);
    int n;
    logic [7:0] exp;
    n = 0;
    @(negedge clk);
    while (!rd_valid_b && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (!rd_valid_b || qb.size() == 0) begin
      failures++;
      $display("FAIL %s: rd_valid=%0b required 1, queued=%0d", name, rd_valid_b, qb.size());
    end else begin
      exp = qb.pop_front();
      if (rd_data_b !== exp) begin
        failures++;
        $display("FAIL %s: rd_data=%h required %h", name, rd_data_b, exp);
      end
      rd_ready_b = 1'b1;
      @(negedge clk);
      rd_ready_b = 1'b0;
    end
  endtask

  task automatic drain_b();
    @(negedge clk);
    rd_ready_b = 1'b1;
    repeat (8) @(negedge clk);
    rd_ready_b = 1'b0;
    qb.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wait_cycles(5);
    @(negedge clk);
    checks++;
    if ({rd_valid_a, parity_err_a, frame_err_a, overflow_a, busy_a} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: v/pe/fe/ov/busy=%b required 00000",
               {rd_valid_a, parity_err_a, frame_err_a, overflow_a, busy_a});
    end
    checks++;
    if (rd_data_a !== 8'h00) begin
      failures++;
      $display("FAIL reset_data: rd_data=%h required 00", rd_data_a);
    end
    reset_n = 1'b1;
    wait_cycles(5);
  endtask

  task automatic test_valid_frame();
    int pe0, fe0;
    pe0 = perr_a; fe0 = ferr_a;
    qa.push_back(8'h1A);
    send_bits(mk_frame(8'h1A, 1'b0, 1'b1), PS2_FRAME_BITS - 1);
    ps2_dat = 1'b1;
    wait_cycles(HALF);
    ps2_clk = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rd_valid_a !== 1'b0) begin
      failures++;
      $display("FAIL valid_early: rd_valid=%0b required 0 in stop fall cycle", rd_valid_a);
    end
    @(negedge clk);
    checks++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 8'h1A) begin
      failures++;
      $display("FAIL valid_latency: rd_valid=%0b rd_data=%h required 1 1a", rd_valid_a, rd_data_a);
    end
    wait_cycles(HALF - 8);
    ps2_clk = 1'b1;
    wait_cycles(HALF);
    checks++;
    if (perr_a != pe0 || ferr_a != fe0) begin
      failures++;
      $display("FAIL valid_no_err: pe/fe pulses=%0d/%0d required 0/0", perr_a - pe0, ferr_a - fe0);
    end
    pop_a("valid_1a");
  endtask

  task automatic test_parity();
    int pe0, fe0, peb0, feb0;
    drain_b();
    pe0 = perr_a; fe0 = ferr_a; peb0 = perr_b; feb0 = ferr_b;
    qb.push_back(8'hF0);
    send_bits(mk_frame(8'hF0, 1'b0, 1'b1), PS2_FRAME_BITS);
    checks++;
    if (perr_a - pe0 != 1 || ferr_a != fe0) begin
      failures++;
      $display("FAIL parity_pulse: pe/fe pulses=%0d/%0d required 1/0", perr_a - pe0, ferr_a - fe0);
    end
    checks++;
    if (rd_valid_a !== 1'b0) begin
      failures++;
      $display("FAIL parity_drop: rd_valid=%0b required 0", rd_valid_a);
    end
    checks++;
    if (perr_b - peb0 != 1 || ferr_b != feb0) begin
      failures++;
      $display("FAIL parity_keep_pulse: pe/fe pulses=%0d/%0d required 1/0", perr_b - peb0, ferr_b - feb0);
    end
    pop_b("parity_keep_f0");
  endtask

  task automatic test_stop_bit();
    int pe0, fe0;
    pe0 = perr_a; fe0 = ferr_a;
    send_bits(mk_frame(8'h1C, 1'b0, 1'b0), PS2_FRAME_BITS);
    checks++;
    if (ferr_a - fe0 != 1 || perr_a != pe0) begin
      failures++;
      $display("FAIL stop_pulse: pe/fe pulses=%0d/%0d required 0/1", perr_a - pe0, ferr_a - fe0);
    end
    checks++;
    if (rd_valid_a !== 1'b0) begin
      failures++;
      $display("FAIL stop_drop: rd_valid=%0b required 0", rd_valid_a);
    end
  endtask

  task automatic test_timeout();
    int fe0;
    fe0 = ferr_a;
    send_bits(mk_frame(8'h29, 1'b0, 1'b1), 5);
    checks++;
    if (busy_a !== 1'b1) begin
      failures++;
      $display("FAIL timeout_busy: busy=%0b required 1", busy_a);
    end
    wait_cycles(49900);
    checks++;
    if (busy_a !== 1'b1 || ferr_a != fe0) begin
      failures++;
      $display("FAIL timeout_early: busy=%0b fe pulses=%0d required 1/0", busy_a, ferr_a - fe0);
    end
    wait_cycles(200);
    checks++;
    if (busy_a !== 1'b0 || ferr_a - fe0 != 1 || rd_valid_a !== 1'b0) begin
      failures++;
      $display("FAIL timeout_abort: busy=%0b fe pulses=%0d rd_valid=%0b required 0/1/0",
               busy_a, ferr_a - fe0, rd_valid_a);
    end
    qa.push_back(8'h29);
    send_good(8'h29);
    pop_a("after_timeout_29");
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) qa.push_back(8'(i));
      send_good(8'(i));
    end
    checks++;
    if (overflow_a !== 1'b1 || rd_valid_a !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set: overflow=%0b rd_valid=%0b required 1/1", overflow_a, rd_valid_a);
    end
    checks++;
    if (overflow_b !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set_b: overflow=%0b required 1", overflow_b);
    end
    for (int i = 0; i < 4; i++) pop_a("overflow_order");
    @(negedge clk);
    checks++;
    if (rd_valid_a !== 1'b0) begin
      failures++;
      $display("FAIL overflow_empty: rd_valid=%0b required 0", rd_valid_a);
    end
    checks++;
    if (overflow_a !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky: overflow=%0b required 1", overflow_a);
    end
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (overflow_a !== 1'b0) begin
      failures++;
      $display("FAIL overflow_clr: overflow=%0b required 0", overflow_a);
    end
  endtask

  task automatic test_glitch_and_reset();
    int pe0, fe0;
    pe0 = perr_a; fe0 = ferr_a;
    wait_cycles(1);
    ps2_clk = 1'b0;
    wait_cycles(1);
    ps2_clk = 1'b1;
    wait_cycles(20);
    checks++;
    if (busy_a !== 1'b0 || ferr_a != fe0 || perr_a != pe0) begin
      failures++;
      $display("FAIL glitch: busy=%0b fe pulses=%0d required 0/0", busy_a, ferr_a - fe0);
    end
    qa.push_back(8'h33);
    send_good(8'h33);
    send_bits(mk_frame(8'h5A, 1'b1, 1'b1), 4);
    checks++;
    if (busy_a !== 1'b1 || rd_valid_a !== 1'b1) begin
      failures++;
      $display("FAIL midframe: busy=%0b rd_valid=%0b required 1/1", busy_a, rd_valid_a);
    end
    reset_n = 1'b0;
    wait_cycles(2);
    @(negedge clk);
    qa.delete();
    checks++;
    if ({rd_valid_a, busy_a, overflow_a, parity_err_a, frame_err_a, rd_valid_b, busy_b} !== 7'b0
        || rd_data_a !== 8'h00) begin
      failures++;
      $display("FAIL midframe_reset: flags=%b rd_data=%h required 0000000 00",
               {rd_valid_a, busy_a, overflow_a, parity_err_a, frame_err_a, rd_valid_b, busy_b}, rd_data_a);
    end
    reset_n = 1'b1;
    wait_cycles(5);
    qa.push_back(8'h5A);
    send_good(8'h5A);
    pop_a("after_reset_5a");
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_parity();
    test_stop_bit();
    test_timeout();
    test_overflow();
    test_glitch_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
Receives device-to-host PS/2 keyboard frames on the raw PS2_CLK/PS2_DAT pins and converts them to 8-bit scancodes. Scancodes are buffered in a small first-word-fall-through FIFO that the CPU I/O port polls and pops through a valid/ready handshake. The block sits directly between the board PS/2 pins and the CPU's keyboard I/O register inside top.

Parameters:
FILTER_LEN, 4, number of consecutive identical synchronized samples needed before a filtered line level changes.
TIMEOUT_CYCLES, 50000, clk cycles without a PS/2 falling edge, mid-frame, before the frame is aborted (1 ms at 50 MHz).
FIFO_DEPTH, 4, scancode FIFO entries; must be a power of two and at least 2.
CHECK_PARITY, 1, 1 = drop bytes with bad odd parity; 0 = keep them and only flag the error.
CHECK_STOP, 1, 1 = drop bytes whose stop bit is 0; 0 = keep them and only flag the error.

Ports:
clk  in  1  system clock (CLOCK_50 domain).
reset_n  in  1  synchronous, active-low reset.
ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
ps2_dat  in  1  raw PS/2 data pin, asynchronous.
rd_data  out  8  head-of-FIFO scancode.
rd_valid  out  1  FIFO not empty.
rd_ready  in  1  pop request; a pop occurs when rd_valid && rd_ready.
parity_err  out  1  one-cycle pulse when a received frame has bad parity.
frame_err  out  1  one-cycle pulse on a bad stop bit, a missing start bit, or a timeout abort.
overflow  out  1  sticky flag: a byte was lost because the FIFO was full.
overflow_clr  in  1  clears overflow.
busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (reset_n low at a clk edge):
  - All outputs go to 0 and rd_data to 8'h00.
  - FIFO is emptied, state goes to IDLE, filtered levels go to 1.
  - A reset mid-frame discards the partial frame.
- Input conditioning:
  - Each pin passes through a 2-flop synchronizer, then the FILTER_LEN filter.
  - fall = filtered clock was 1 last cycle and is 0 this cycle.
  - Data is sampled from the filtered data level in the fall cycle.
  - Pin-to-fall latency is 2 + FILTER_LEN cycles.
- State machine, advancing only on fall except for the timeout:
  - IDLE: data=0 -> DATA with bit_cnt=0. Data=1 -> stay in IDLE and pulse frame_err.
  - DATA: shift the bit in LSB-first (shreg <= {dat, shreg[7:1]}). When bit_cnt==7 go to PARITY, otherwise increment bit_cnt.
  - PARITY: store the bit and go to STOP.
  - STOP: evaluate the frame and go to IDLE.
- Timeout:
  - In any state other than IDLE, a counter runs; it resets to 0 on every fall.
  - When it reaches TIMEOUT_CYCLES-1: go to IDLE, pulse frame_err, write nothing.
  - If a timeout and a fall land in the same cycle, the timeout wins.
- Frame evaluation, in the STOP fall cycle:
  - par_ok = ^{shreg, parity_bit} == 1 (odd parity).
  - stop_ok = stop bit == 1.
  - parity_err pulses if !par_ok; frame_err pulses if !stop_ok. Both may pulse together.
  - The byte is pushed unless (CHECK_PARITY && !par_ok) || (CHECK_STOP && !stop_ok).
  - Error pulses appear in the cycle after the STOP fall, aligned with the push.
- FIFO:
  - Push is registered; rd_valid rises 1 cycle after the STOP fall when the FIFO was empty.
  - rd_data is valid combinationally whenever rd_valid is high.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Full is the MSBs differing with the lower bits equal.
- FIFO boundary cases:
  - Push while full with no pop: the byte is dropped and overflow is set.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Push and pop in the same cycle while empty: the push occurs only; the pop is ignored since rd_valid=0.
  - overflow_clr and a new overflow in the same cycle: overflow stays 1.
- Scope: no host-to-device transmit and no scancode translation (F0/E0 prefixes are passed through as plain bytes).

Decomposition:
- Shared header ps2_defs.vh:
  - State encodings IDLE/DATA/PARITY/STOP (2-bit).
  - PS2_FRAME_BITS=11 and PS2_DATA_BITS=8.
- Sub-module ps2_input_filter (synchronizer plus FILTER_LEN filter, parameterised, reset value 1), instantiated once per pin.
- FIFO inline.

Test Plan:
- Valid frame, 8'h1A with parity 0 and stop 1, PS/2 half-period 40 clk -> rd_valid=1 and rd_data=8'h1A one cycle after the stop fall; no error pulses.
- 8'hF0 with parity 0 (bad) and CHECK_PARITY=1 -> parity_err pulses once, FIFO stays empty. Same frame with CHECK_PARITY=0 -> 8'hF0 is pushed and parity_err still pulses.
- Stop bit 0 on 8'h1C -> frame_err pulses and nothing is pushed (CHECK_STOP=1).
- Stop PS/2 clock after DATA3 for 50000 cycles -> frame_err, busy=0. A following valid 8'h29 frame is received correctly.
- 5 valid frames 8'h01..8'h05, rd_ready=0, depth 4 -> overflow=1 and FIFO holds 01..04. Pop 4 -> data in order, rd_valid=0. overflow_clr -> overflow=0.
- 1-cycle glitch low on ps2_clk in IDLE and reset_n low mid-frame -> no state change for the glitch; after reset, FIFO empty, busy=0, outputs 0.
